// File: rtl/display_cfg_sequencer.sv
// display_cfg_sequencer: AXI4-Lite master that writes a register bank
// from a configuration vector and optionally reads it back to verify.
module display_cfg_sequencer #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic [32*NUM_REGS-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [3:0]               err_index,
  output logic [31:0]              m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [31:0]              m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE, S_ERR
  } state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NUM_REGS-1:0][31:0]      shadow_q, shadow_d;
  logic                           awvalid_q, awvalid_d;
  logic                           wvalid_q, wvalid_d;
  logic                           bready_q, bready_d;
  logic                           arvalid_q, arvalid_d;
  logic                           rready_q, rready_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;
  logic [1:0]                     err_code_q, err_code_d;
  logic [3:0]                     err_index_q, err_index_d;

  logic [31:0] cur_addr;
  logic [31:0] cur_data;

  assign cur_addr = BASE_ADDR + (32'(idx_q) << 2);
  assign cur_data = shadow_q[idx_q];

  // State and handshake registers; async reset returns everything to idle
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
      err_index_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
    end
  end

  // Next-state: one AXI transaction outstanding at a time, write then verify
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          shadow_d    = cfg_data;
          idx_d       = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_code_d  = 2'b00;
          err_index_d = 4'h0;
          busy_d      = 1'b1;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            state_d     = S_ERR;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            err_code_d  = 2'b01;
            err_index_d = 4'(idx_q);
          end else if (idx_q == LAST) begin
            if (VERIFY) begin
              idx_d     = '0;
              arvalid_d = 1'b1;
              state_d   = S_RD_ADDR;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            idx_d     = idx_q + IW'(1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d = 1'b0;
          if (m_axi_rresp != 2'b00 || m_axi_rdata != cur_data) begin
            state_d     = S_ERR;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            err_code_d  = (m_axi_rresp != 2'b00) ? 2'b10 : 2'b11;
            err_index_d = 4'(idx_q);
          end else if (idx_q == LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + IW'(1);
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign err_index     = err_index_q;
  assign m_axi_awaddr  = cur_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = cur_data;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
